// File: rtl/load_buffer_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : load_buffer_tracker
//  Description : Tracks outstanding load requests between the issue stage and
//                the data cache. Each slot carries a scoreboard transaction ID
//                and moves through FREE -> PENDING -> DONE -> FREE. If a flush
//                arrives while the load is still in the cache, the slot moves
//                PENDING -> KILLED -> FREE instead.
//                Slots are allocated lowest-index first. The slot index is the
//                request tag sent to the cache. Responses may return out of
//                order. Completed loads go to writeback lowest-index first.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i            : clock, all state updates on the rising edge
//    rst_i            : synchronous active-high reset
//    flush_i          : kill every in-flight load
//    alloc_valid_i    : new load request
//    alloc_ready_o    : a slot is free and no flush is in progress
//    alloc_trans_id_i : scoreboard ID of the new load
//    alloc_tag_o      : slot index handed to the cache as request ID
//    rsp_valid_i      : cache response strobe (cannot be back-pressured)
//    rsp_tag_i        : slot index of the response
//    rsp_data_i       : load data
//    out_valid_o      : completed load available
//    out_ready_i      : writeback accepts the completed load
//    out_trans_id_o   : ID of the delivered load
//    out_data_o       : data of the delivered load
//    count_o          : number of non-FREE slots
//    err_o            : one-cycle pulse after a protocol-violating response
// ============================================================================
module load_buffer_tracker #(
    parameter int NrEntries    = 2,
    parameter int TransIdWidth = 2,
    parameter int DataWidth    = 32,
    localparam int IdxW        = (NrEntries > 1) ? $clog2(NrEntries) : 1,
    localparam int CntW        = $clog2(NrEntries + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    alloc_valid_i,
    output logic                    alloc_ready_o,
    input  logic [TransIdWidth-1:0] alloc_trans_id_i,
    output logic [IdxW-1:0]         alloc_tag_o,
    input  logic                    rsp_valid_i,
    input  logic [IdxW-1:0]         rsp_tag_i,
    input  logic [DataWidth-1:0]    rsp_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [TransIdWidth-1:0] out_trans_id_o,
    output logic [DataWidth-1:0]    out_data_o,
    output logic [CntW-1:0]         count_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2,
        SLOT_KILLED  = 2'd3
    } slot_state_e;

    // One extra bit so that the entry count itself is representable
    // (for example 16 entries need a 4-bit tag, but the value 16 needs 5 bits).
    localparam logic [IdxW:0] c_NR_ENTRIES = (IdxW + 1)'(NrEntries);

    slot_state_e               r_state [NrEntries];
    logic [TransIdWidth-1:0]   r_tid   [NrEntries];
    logic [DataWidth-1:0]      r_data  [NrEntries];
    logic                      r_err;

    slot_state_e               w_state_nxt [NrEntries];
    logic [TransIdWidth-1:0]   w_tid_nxt   [NrEntries];
    logic [DataWidth-1:0]      w_data_nxt  [NrEntries];

    logic                      w_any_free;
    logic [IdxW-1:0]           w_free_idx;
    logic                      w_any_done;
    logic [IdxW-1:0]           w_done_idx;
    logic [TransIdWidth-1:0]   w_sel_tid;
    logic [DataWidth-1:0]      w_sel_data;
    logic [CntW-1:0]           w_count;

    logic                      w_rsp_in_range;
    slot_state_e               w_rsp_slot_state;
    logic                      w_rsp_err;

    logic                      w_alloc_fire;
    logic                      w_out_valid;
    logic                      w_out_fire;
    logic [NrEntries-1:0]      w_alloc_hit;
    logic [NrEntries-1:0]      w_rsp_hit;
    logic [NrEntries-1:0]      w_out_hit;

    // ------------------------------------------------------------------
    // Priority scans over the registered slot state. The loops run from the
    // highest index down, so the lowest matching index is the last write and
    // wins. The selected output payload is muxed inside the same scan.
    // Because of this, no array is ever indexed by a tag that could be out
    // of range.
    // ------------------------------------------------------------------
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_any_done = 1'b0;
        w_done_idx = '0;
        w_sel_tid  = '0;
        w_sel_data = '0;
        w_count    = '0;
        for (int i = NrEntries - 1; i >= 0; i--) begin
            if (r_state[i] == SLOT_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = IdxW'(i);
            end
            if (r_state[i] == SLOT_DONE) begin
                w_any_done = 1'b1;
                w_done_idx = IdxW'(i);
                w_sel_tid  = r_tid[i];
                w_sel_data = r_data[i];
            end
            if (r_state[i] != SLOT_FREE) begin
                w_count = w_count + CntW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response classification. An out-of-range tag reads back as FREE,
    // so it falls into the same error path as a stray response.
    // ------------------------------------------------------------------
    assign w_rsp_in_range = ({1'b0, rsp_tag_i} < c_NR_ENTRIES);

    always_comb begin
        w_rsp_slot_state = SLOT_FREE;
        for (int i = 0; i < NrEntries; i++) begin
            if (rsp_tag_i == IdxW'(i)) begin
                w_rsp_slot_state = r_state[i];
            end
        end
    end

    assign w_rsp_err = rsp_valid_i &&
                       (!w_rsp_in_range ||
                        (w_rsp_slot_state == SLOT_FREE) ||
                        (w_rsp_slot_state == SLOT_DONE));

    // ------------------------------------------------------------------
    // Handshakes. Allocation and delivery are both blocked during a flush.
    // As a result, a flush-cycle out handshake never frees a slot as
    // "delivered".
    // ------------------------------------------------------------------
    assign w_alloc_fire = alloc_valid_i && alloc_ready_o;
    assign w_out_valid  = w_any_done && !flush_i;
    assign w_out_fire   = w_out_valid && out_ready_i;

    always_comb begin
        w_alloc_hit = '0;
        w_rsp_hit   = '0;
        w_out_hit   = '0;
        for (int i = 0; i < NrEntries; i++) begin
            w_alloc_hit[i] = w_alloc_fire && (w_free_idx == IdxW'(i));
            w_rsp_hit[i]   = rsp_valid_i  && (rsp_tag_i  == IdxW'(i));
            w_out_hit[i]   = w_out_fire   && (w_done_idx == IdxW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Per-slot next state. Each event can only act on a slot in a specific
    // state: alloc acts on FREE, out acts on DONE, and a legal response acts
    // on PENDING or KILLED. Therefore alloc, rsp and out on distinct slots
    // never interfere with each other.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NrEntries; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tid_nxt[i]   = r_tid[i];
            w_data_nxt[i]  = r_data[i];
            case (r_state[i])
                SLOT_FREE: begin
                    if (w_alloc_hit[i]) begin
                        w_state_nxt[i] = SLOT_PENDING;
                        w_tid_nxt[i]   = alloc_trans_id_i;
                    end
                end
                SLOT_PENDING: begin
                    if (w_rsp_hit[i]) begin
                        // When data arrives in the flush cycle, the slot is
                        // retired immediately rather than marked KILLED,
                        // because no further response is coming for it.
                        if (flush_i) begin
                            w_state_nxt[i] = SLOT_FREE;
                        end else begin
                            w_state_nxt[i] = SLOT_DONE;
                            w_data_nxt[i]  = rsp_data_i;
                        end
                    end else if (flush_i) begin
                        w_state_nxt[i] = SLOT_KILLED;
                    end
                end
                SLOT_DONE: begin
                    if (flush_i || w_out_hit[i]) begin
                        w_state_nxt[i] = SLOT_FREE;
                    end
                end
                SLOT_KILLED: begin
                    if (w_rsp_hit[i]) begin
                        w_state_nxt[i] = SLOT_FREE;
                    end
                end
                default: begin
                    w_state_nxt[i] = SLOT_FREE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                r_state[i] <= SLOT_FREE;
                r_tid[i]   <= '0;
                r_data[i]  <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NrEntries; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tid[i]   <= w_tid_nxt[i];
                r_data[i]  <= w_data_nxt[i];
            end
            r_err <= w_rsp_err;
        end
    end

    assign alloc_ready_o  = w_any_free && !flush_i;
    assign alloc_tag_o    = w_free_idx;
    assign out_valid_o    = w_out_valid;
    assign out_trans_id_o = w_sel_tid;
    assign out_data_o     = w_sel_data;
    assign count_o        = w_count;
    assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_buffer_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_buffer_tracker
//  Description : Self-checking bench for load_buffer_tracker (2 entries).
//                Runs a table of per-cycle input/expected-output records,
//                a delivery scoreboard, and a hand-written reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_buffer_tracker;

    localparam int NrEntries    = 2;
    localparam int TransIdWidth = 2;
    localparam int DataWidth    = 32;
    localparam int IdxW         = 1;
    localparam int CntW         = 2;

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic                    alloc_valid_i;
    logic                    alloc_ready_o;
    logic [TransIdWidth-1:0] alloc_trans_id_i;
    logic [IdxW-1:0]         alloc_tag_o;
    logic                    rsp_valid_i;
    logic [IdxW-1:0]         rsp_tag_i;
    logic [DataWidth-1:0]    rsp_data_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [TransIdWidth-1:0] out_trans_id_o;
    logic [DataWidth-1:0]    out_data_o;
    logic [CntW-1:0]         count_o;
    logic                    err_o;

    always #5 clk = ~clk;

    load_buffer_tracker #(
        .NrEntries    (NrEntries),
        .TransIdWidth (TransIdWidth),
        .DataWidth    (DataWidth)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_trans_id_i (alloc_trans_id_i),
        .alloc_tag_o      (alloc_tag_o),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_tag_i        (rsp_tag_i),
        .rsp_data_i       (rsp_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_trans_id_o   (out_trans_id_o),
        .out_data_o       (out_data_o),
        .count_o          (count_o),
        .err_o            (err_o)
    );

    // One record per clock cycle. The inputs are driven after the falling
    // edge. The expected values describe the outputs just before the next
    // rising edge. err reflects the previous cycle's response.
    typedef struct {
        string       name;
        logic [31:0] flush, av, aid, rv, rtag, rdata, ordy;
        logic [31:0] e_ready, e_tag, e_ov, e_tid, e_data, e_cnt, e_err;
        logic [31:0] sb_push, sb_tid;
    } vec_t;

    typedef struct {
        logic [31:0] tid;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: actual=0x%0h required=0x%0h", name, what, act, exp);
        end
    endtask

    task automatic add(input string name,
                       input logic [31:0] flush, av, aid, rv, rtag, rdata, ordy,
                       input logic [31:0] e_ready, e_tag, e_ov, e_tid, e_data, e_cnt, e_err,
                       input logic [31:0] sb_push, sb_tid);
        vec_t v;
        v.name = name;
        v.flush = flush; v.av = av; v.aid = aid; v.rv = rv;
        v.rtag = rtag; v.rdata = rdata; v.ordy = ordy;
        v.e_ready = e_ready; v.e_tag = e_tag; v.e_ov = e_ov; v.e_tid = e_tid;
        v.e_data = e_data; v.e_cnt = e_cnt; v.e_err = e_err;
        v.sb_push = sb_push; v.sb_tid = sb_tid;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic fl, av, input logic [1:0] aid,
                          input logic rv, rt, input logic [31:0] rd, input logic ordy);
        flush_i          = fl;
        alloc_valid_i    = av;
        alloc_trans_id_i = aid;
        rsp_valid_i      = rv;
        rsp_tag_i        = rt;
        rsp_data_i       = rd;
        out_ready_i      = ordy;
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge clk);
        set_in(v.flush[0], v.av[0], v.aid[1:0], v.rv[0], v.rtag[0], v.rdata, v.ordy[0]);
        if (v.sb_push[0]) begin
            e.tid  = v.sb_tid;
            e.data = v.rdata;
            sb_q.push_back(e);
        end
        #2;
        check(v.name, "alloc_ready", 32'(alloc_ready_o), v.e_ready);
        if (v.e_ready[0]) check(v.name, "alloc_tag", 32'(alloc_tag_o), v.e_tag);
        check(v.name, "out_valid", 32'(out_valid_o), v.e_ov);
        if (v.e_ov[0]) begin
            check(v.name, "out_trans_id", 32'(out_trans_id_o), v.e_tid);
            check(v.name, "out_data", out_data_o, v.e_data);
        end
        check(v.name, "count", 32'(count_o), v.e_cnt);
        check(v.name, "err", 32'(err_o), v.e_err);
        // Delivery scoreboard: every accepted output must match the oldest
        // expected completion.
        if (out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s.sb: actual=delivery id 0x%0h required=no delivery",
                         v.name, out_trans_id_o);
            end else begin
                e = sb_q.pop_front();
                check(v.name, "sb_tid", 32'(out_trans_id_o), e.tid);
                check(v.name, "sb_data", out_data_o, e.data);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #2;
        check("reset", "alloc_ready", 32'(alloc_ready_o), 32'd1);
        check("reset", "alloc_tag", 32'(alloc_tag_o), 32'd0);
        check("reset", "out_valid", 32'(out_valid_o), 32'd0);
        check("reset", "count", 32'(count_o), 32'd0);
        check("reset", "out_trans_id", 32'(out_trans_id_o), 32'd0);
        check("reset", "out_data", out_data_o, 32'd0);
        check("reset", "err", 32'(err_o), 32'd0);

        //   name                fl av aid rv rt rdata    ordy  rdy tag ov tid data     cnt err  sb tid
        // Fill both slots, then return responses out of order.
        add("fill_a",            0, 1, 1,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        add("fill_b",            0, 1, 2,  0, 0, 0,       0,    1,  1,  0, 0, 0,       1,  0,   0, 0);
        add("full",              0, 0, 0,  0, 0, 0,       0,    0,  0,  0, 0, 0,       2,  0,   0, 0);
        add("rsp_t1",            0, 0, 0,  1, 1, 'hBEEF,  1,    0,  0,  0, 0, 0,       2,  0,   1, 2);
        add("ooo_first",         0, 0, 0,  1, 0, 'hCAFE,  1,    0,  0,  1, 2, 'hBEEF,  2,  0,   1, 1);
        add("ooo_second",        0, 0, 0,  0, 0, 0,       1,    1,  1,  1, 1, 'hCAFE,  1,  0,   0, 0);
        add("drained",           0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        // Backpressure: DONE slot held for five cycles, then released.
        add("bp_alloc",          0, 1, 3,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        add("bp_rsp",            0, 0, 0,  1, 0, 'h1234,  0,    1,  1,  0, 0, 0,       1,  0,   1, 3);
        for (int k = 0; k < 5; k++)
            add("bp_hold",       0, 0, 0,  0, 0, 0,       0,    1,  1,  1, 3, 'h1234,  1,  0,   0, 0);
        add("bp_release",        0, 0, 0,  0, 0, 0,       1,    1,  1,  1, 3, 'h1234,  1,  0,   0, 0);
        add("bp_freed",          0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        // Flush with slot 0 PENDING and slot 1 DONE; handshake ignored.
        add("fl_alloc0",         0, 1, 1,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        add("fl_alloc1",         0, 1, 2,  0, 0, 0,       0,    1,  1,  0, 0, 0,       1,  0,   0, 0);
        add("fl_rsp1",           0, 0, 0,  1, 1, 'h5555,  0,    0,  0,  0, 0, 0,       2,  0,   0, 0);
        add("flush",             1, 0, 0,  0, 0, 0,       1,    0,  0,  0, 0, 0,       2,  0,   0, 0);
        add("fl_after",          0, 0, 0,  0, 0, 0,       1,    1,  1,  0, 0, 0,       1,  0,   0, 0);
        add("fl_late_rsp",       0, 0, 0,  1, 0, 'h7777,  1,    1,  1,  0, 0, 0,       1,  0,   0, 0);
        add("fl_done",           0, 0, 0,  0, 0, 0,       1,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        // Stray response to a FREE slot.
        add("err_rsp",           0, 0, 0,  1, 1, 'h9,     0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        add("err_pulse",         0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  1,   0, 0);
        add("err_clear",         0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        // Response in the flush cycle retires a PENDING slot; flush blocks alloc.
        add("fr_alloc",          0, 1, 3,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        add("fr_flush_rsp",      1, 0, 0,  1, 0, 'hAAAA,  0,    0,  0,  0, 0, 0,       1,  0,   0, 0);
        add("fr_done",           0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        // Duplicate response to a DONE slot, then alloc + delivery in one edge.
        add("de_alloc",          0, 1, 1,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);
        add("de_rsp",            0, 0, 0,  1, 0, 'h11,    0,    1,  1,  0, 0, 0,       1,  0,   1, 1);
        add("de_dup_rsp",        0, 0, 0,  1, 0, 'h22,    0,    1,  1,  1, 1, 'h11,    1,  0,   0, 0);
        add("de_deliver_alloc",  0, 1, 2,  0, 0, 0,       1,    1,  1,  1, 1, 'h11,    1,  1,   0, 0);
        add("de_after",          0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       1,  0,   0, 0);
        add("de_rsp1",           0, 0, 0,  1, 1, 'h33,    1,    1,  0,  0, 0, 0,       1,  0,   1, 2);
        add("de_out1",           0, 0, 0,  0, 0, 0,       1,    1,  0,  1, 2, 'h33,    1,  0,   0, 0);
        add("de_empty",          0, 0, 0,  0, 0, 0,       0,    1,  0,  0, 0, 0,       0,  0,   0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        check("scoreboard", "left_over", 32'(sb_q.size()), 32'd0);

        // Reset mid-run with two undelivered DONE slots.
        @(negedge clk); set_in(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); set_in(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk); set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'hA1, 1'b0);
        @(negedge clk); set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 32'hB2, 1'b0);
        @(negedge clk); set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #2;
        check("rst_pre", "out_valid", 32'(out_valid_o), 32'd1);
        check("rst_pre", "count", 32'(count_o), 32'd2);
        check("rst_pre", "out_data", out_data_o, 32'hA1);
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'hDD, 1'b0);
        #2;
        check("rst_post", "out_valid", 32'(out_valid_o), 32'd0);
        check("rst_post", "count", 32'(count_o), 32'd0);
        check("rst_post", "alloc_tag", 32'(alloc_tag_o), 32'd0);
        check("rst_post", "alloc_ready", 32'(alloc_ready_o), 32'd1);
        check("rst_post", "err", 32'(err_o), 32'd0);
        @(negedge clk); set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #2;
        check("rst_stray", "err", 32'(err_o), 32'd1);
        check("rst_stray", "count", 32'(count_o), 32'd0);
        check("rst_stray", "out_valid", 32'(out_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
